// File: rtl/icache_np.sv
// N-way set-associative read-only L1 instruction cache.
// Round-robin victim choice, fetch abort, single-line invalidate and flush sweep.
module icache_np #(
   parameter int WAYS   = 2,
   parameter int LINES  = 64,
   parameter int LINE_W = 8,
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_icache_on,
   input  logic              i_new_request,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_fetch_abort,
   output logic              o_ready,
   output logic              o_data_valid,
   output logic [31:0]       o_data_out,
   output logic              o_l1_request,
   output logic [ADDR_W-1:0] o_l1_addr,
   output logic [4:0]        o_l1_size,
   input  logic              i_l1_ack,
   input  logic              i_l1_data_valid,
   input  logic [31:0]       i_l1_data,
   input  logic              i_inv_valid,
   input  logic [ADDR_W-3:0] i_inv_addr,
   output logic              o_inv_done,
   input  logic              i_flush,
   output logic              o_flush_busy
);

   localparam int OFF_W = $clog2(LINE_W);
   localparam int SET_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - 2 - OFF_W - SET_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_REQ,
      S_FILL,
      S_DONE,
      S_INV_RD,
      S_INV_WR,
      S_FLUSH
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [TAG_W-1:0]  r_tag    [WAYS][LINES];
   logic [31:0]       r_data   [WAYS][LINES][LINE_W];
   logic [LINES-1:0]  r_valid  [WAYS];
   logic [TAG_W-1:0]  r_tag_rd [WAYS];
   logic [31:0]       r_dat_rd [WAYS];

   logic [ADDR_W-1:0] r_addr;
   logic [WAY_W-1:0]  r_rr;
   logic [WAY_W-1:0]  r_victim;
   logic [OFF_W-1:0]  r_wc;
   logic [SET_W-1:0]  r_fcnt;
   logic              r_abort;
   logic              r_flush_pend;
   logic              r_fdv;
   logic [31:0]       r_fword;

   logic [SET_W-1:0]  w_set;
   logic [OFF_W-1:0]  w_off;
   logic [TAG_W-1:0]  w_tag;
   logic [SET_W-1:0]  w_in_set;
   logic [OFF_W-1:0]  w_in_off;
   logic [SET_W-1:0]  w_inv_set;
   logic [TAG_W-1:0]  w_inv_tag;
   logic [WAYS-1:0]   w_hit_vec;
   logic [31:0]       w_hit_word;
   logic              w_hit;
   logic              w_lk_hit;
   logic              w_flush_pend;
   logic              w_gate;
   logic              w_accept;
   logic              w_beat;
   logic              w_last;

   assign w_set     = r_addr[2+OFF_W +: SET_W];
   assign w_off     = r_addr[2 +: OFF_W];
   assign w_tag     = r_addr[ADDR_W-1 -: TAG_W];
   assign w_in_set  = i_addr[2+OFF_W +: SET_W];
   assign w_in_off  = i_addr[2 +: OFF_W];
   assign w_inv_set = i_inv_addr[OFF_W +: SET_W];
   assign w_inv_tag = i_inv_addr[ADDR_W-3 -: TAG_W];

   always_comb begin
      w_hit_vec  = '0;
      w_hit_word = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_hit_vec[w] = r_valid[w][w_set] && (r_tag_rd[w] == w_tag);
         if (w_hit_vec[w]) w_hit_word = w_hit_word | r_dat_rd[w];
      end
   end

   assign w_hit        = i_icache_on & (|w_hit_vec);
   assign w_lk_hit     = (r_state == S_LOOKUP) & w_hit;
   assign w_flush_pend = i_flush | r_flush_pend;
   // Pending maintenance holds off new fetches so it cannot be starved.
   assign w_gate       = ~w_flush_pend & ~i_inv_valid;
   assign w_accept     = o_ready & i_new_request;
   assign w_beat       = (r_state == S_FILL) & i_l1_data_valid;
   assign w_last       = w_beat & (r_wc == OFF_W'(LINE_W - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_ready      = 1'b0;
      o_l1_request = 1'b0;
      o_inv_done   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            o_ready = w_gate;
            if (w_flush_pend)       w_next = S_FLUSH;
            else if (i_inv_valid)   w_next = S_INV_RD;
            else if (i_new_request) w_next = S_LOOKUP;
         end
         S_LOOKUP: begin
            o_ready = w_hit & w_gate;
            if (!w_hit)        w_next = S_REQ;
            else if (w_accept) w_next = S_LOOKUP;
            else               w_next = S_IDLE;
         end
         S_REQ: begin
            o_l1_request = 1'b1;
            if (i_l1_ack) w_next = S_FILL;
         end
         S_FILL: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            o_ready = w_gate;
            w_next  = w_accept ? S_LOOKUP : S_IDLE;
         end
         S_INV_RD: w_next = S_INV_WR;
         S_INV_WR: begin
            o_inv_done = 1'b1;
            w_next     = S_IDLE;
         end
         S_FLUSH: begin
            if (r_fcnt == SET_W'(LINES - 1)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign o_data_valid = w_lk_hit | r_fdv;
   assign o_data_out   = w_lk_hit ? w_hit_word :
                         (r_fdv ? r_fword : 32'h0);
   assign o_l1_addr    = {r_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
   assign o_l1_size    = 5'(LINE_W - 1);
   assign o_flush_busy = r_flush_pend | (r_state == S_FLUSH);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid      <= '{default: '0};
         r_addr       <= '0;
         r_rr         <= '0;
         r_victim     <= '0;
         r_wc         <= '0;
         r_fcnt       <= '0;
         r_abort      <= 1'b0;
         r_flush_pend <= 1'b0;
         r_fdv        <= 1'b0;
         r_fword      <= '0;
      end else begin
         r_fdv <= 1'b0;
         if (r_state == S_IDLE) r_flush_pend <= 1'b0;
         else if (i_flush)      r_flush_pend <= 1'b1;
         if (w_accept) r_addr <= i_addr;
         if (r_state == S_LOOKUP && !w_hit) begin
            r_victim <= r_rr;
            r_rr     <= (r_rr == WAY_W'(WAYS - 1)) ? '0 : r_rr + 1'b1;
         end
         if (r_state == S_DONE) begin
            r_abort <= 1'b0;
         end else if (i_fetch_abort &&
                      ((r_state == S_LOOKUP && !w_hit) ||
                       r_state == S_REQ || r_state == S_FILL)) begin
            r_abort <= 1'b1;
         end
         // The victim is about to be overwritten, so it stops hitting now.
         if (r_state == S_REQ && i_l1_ack)
            r_valid[r_victim][w_set] <= 1'b0;
         if (w_beat) begin
            r_wc <= r_wc + 1'b1;
            if (r_wc == w_off && !(r_abort || i_fetch_abort)) begin
               r_fdv   <= 1'b1;
               r_fword <= i_l1_data;
            end
            if (w_last && i_icache_on)
               r_valid[r_victim][w_set] <= 1'b1;
         end
         if (r_state == S_INV_WR) begin
            for (int w = 0; w < WAYS; w++)
               if (r_valid[w][w_inv_set] && r_tag_rd[w] == w_inv_tag)
                  r_valid[w][w_inv_set] <= 1'b0;
         end
         if (r_state == S_FLUSH) begin
            for (int w = 0; w < WAYS; w++)
               r_valid[w][r_fcnt] <= 1'b0;
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   // Tag and data banks carry no reset; the valid bits qualify them.
   always_ff @(posedge i_clk) begin
      if (w_beat)
         r_data[r_victim][w_set][r_wc] <= i_l1_data;
      if (w_last && i_icache_on)
         r_tag[r_victim][w_set] <= w_tag;
      if (w_accept) begin
         for (int w = 0; w < WAYS; w++) begin
            r_tag_rd[w] <= r_tag[w][w_in_set];
            r_dat_rd[w] <= r_data[w][w_in_set][w_in_off];
         end
      end else if (r_state == S_INV_RD) begin
         for (int w = 0; w < WAYS; w++)
            r_tag_rd[w] <= r_tag[w][w_inv_set];
      end
   end

   a_fill_beat: assert property (@(posedge i_clk) disable iff (i_rst)
      i_l1_data_valid |-> (r_state == S_FILL));
   a_ack_req: assert property (@(posedge i_clk) disable iff (i_rst)
      i_l1_ack |-> o_l1_request);

endmodule

// File: tb/tb_icache_np.sv
// Directed bench for icache_np: L1 responder, expected-word queue,
// miss/hit, abort, conflict, invalidate, flush and async-reset sequences.
module tb_icache_np;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        icache_on = 1'b1;
   logic        new_request = 1'b0;
   logic [31:0] addr = '0;
   logic        fetch_abort = 1'b0;
   logic        ready;
   logic        data_valid;
   logic [31:0] data_out;
   logic        l1_request;
   logic [31:0] l1_addr;
   logic [4:0]  l1_size;
   logic        l1_ack = 1'b0;
   logic        l1_data_valid = 1'b0;
   logic [31:0] l1_data = '0;
   logic        inv_valid = 1'b0;
   logic [29:0] inv_addr = '0;
   logic        inv_done;
   logic        flush = 1'b0;
   logic        flush_busy;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   bit inv_on = 1'b0;
   bit flush_on = 1'b0;

   icache_np #(.WAYS(2), .LINES(64), .LINE_W(8), .ADDR_W(32)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_icache_on(icache_on),
      .i_new_request(new_request),
      .i_addr(addr),
      .i_fetch_abort(fetch_abort),
      .o_ready(ready),
      .o_data_valid(data_valid),
      .o_data_out(data_out),
      .o_l1_request(l1_request),
      .o_l1_addr(l1_addr),
      .o_l1_size(l1_size),
      .i_l1_ack(l1_ack),
      .i_l1_data_valid(l1_data_valid),
      .i_l1_data(l1_data),
      .i_inv_valid(inv_valid),
      .i_inv_addr(inv_addr),
      .o_inv_done(inv_done),
      .i_flush(flush),
      .o_flush_busy(flush_busy)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] e;
      e = 'x;
      chk({tag, "_queued"}, 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk(tag, data_out, e);
   endtask

   // Issue one fetch at a negedge; on a miss act as the L1 arbiter.
   task automatic fetch(input logic [31:0] a, input bit hit,
                        input bit abort, input int ackw,
                        input bit rdy_done);
      logic [31:0] base;
      int tgt;
      base = {a[31:5], 5'b0};
      tgt  = int'(a[4:2]);
      chk("ready_before_req", ready, 1);
      new_request = 1'b1;
      addr = a;
      if (!abort) exp_q.push_back(mem_word(a));
      tick();
      new_request = 1'b0;
      if (hit) begin
         chk("hit_dv", data_valid, 1);
         pop_chk("hit_data");
      end else begin
         chk("miss_dv", data_valid, 0);
         tick();
         chk("l1_request", l1_request, 1);
         chk("l1_addr", l1_addr, base);
         chk("l1_size", 32'(l1_size), 7);
         repeat (ackw) tick();
         l1_ack = 1'b1;
         tick();
         l1_ack = 1'b0;
         chk("req_dropped", l1_request, 0);
         if (abort) begin
            fetch_abort = 1'b1;
            tick();
            fetch_abort = 1'b0;
         end
         for (int k = 0; k < 8; k++) begin
            l1_data_valid = 1'b1;
            l1_data = mem_word(base + 32'(4 * k));
            if (k == 3 && inv_on) inv_valid = 1'b1;
            if (k == 3 && flush_on) flush = 1'b1;
            tick();
            l1_data_valid = 1'b0;
            flush = 1'b0;
            if (k == 3 && flush_on) chk("flush_busy_mid", flush_busy, 1);
            chk("fill_dv", data_valid, 32'(k == tgt && !abort));
            if (k == tgt && !abort) pop_chk("fill_data");
         end
         chk("done_ready", ready, 32'(rdy_done));
      end
   endtask

   initial begin
      int n;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_dv", data_valid, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_l1req", l1_request, 0);
      chk("rst_invdone", inv_done, 0);
      chk("rst_fbusy", flush_busy, 0);
      rst = 1'b0;
      tick();

      // cold miss, then hit on the next word
      fetch(32'h100, 0, 0, 0, 1);
      fetch(32'h104, 1, 0, 0, 1);
      tick();
      // uncached fetch: always misses, target is last word
      icache_on = 1'b0;
      fetch(32'h11C, 0, 0, 2, 1);
      icache_on = 1'b1;
      fetch(32'h100, 1, 0, 0, 1);
      fetch(32'h11C, 1, 0, 0, 1);
      // abort during fill
      fetch(32'h200, 0, 1, 1, 1);
      fetch(32'h200, 1, 0, 0, 1);
      // three lines in set 0
      fetch(32'h000, 0, 0, 0, 1);
      fetch(32'h800, 0, 0, 0, 1);
      fetch(32'h1000, 0, 0, 0, 1);
      fetch(32'h800, 1, 0, 0, 1);
      fetch(32'h1000, 1, 0, 0, 1);

      // invalidate raised while a fill is running
      inv_addr = 30'(32'h800 >> 2);
      inv_on = 1'b1;
      fetch(32'h300, 0, 0, 0, 0);
      inv_on = 1'b0;
      chk("inv_done_in_done", inv_done, 0);
      tick();
      chk("inv_idle_ready", ready, 0);
      chk("inv_done_idle", inv_done, 0);
      tick();
      chk("inv_done_rd", inv_done, 0);
      tick();
      chk("inv_done_wr", inv_done, 1);
      inv_valid = 1'b0;
      tick();
      chk("inv_done_clear", inv_done, 0);
      fetch(32'h1000, 1, 0, 0, 1);
      fetch(32'h800, 0, 0, 0, 1);
      fetch(32'h000, 0, 0, 0, 1);
      tick();

      // invalidate of an absent line still completes
      inv_addr = 30'(32'h4000 >> 2);
      inv_valid = 1'b1;
      tick();
      chk("inv_miss_rd", inv_done, 0);
      tick();
      chk("inv_miss_done", inv_done, 1);
      inv_valid = 1'b0;
      tick();
      fetch(32'h000, 1, 0, 0, 1);
      fetch(32'h800, 1, 0, 0, 1);

      // flush pulsed during a miss
      flush_on = 1'b1;
      fetch(32'h400, 0, 0, 0, 0);
      flush_on = 1'b0;
      chk("flush_busy_done", flush_busy, 1);
      n = 0;
      while (flush_busy && n < 300) begin
         tick();
         n++;
         if (n == 30) chk("flush_ready_low", ready, 0);
      end
      chk("flush_cycles", n, 66);
      chk("flush_ready_after", ready, 1);
      fetch(32'h100, 0, 0, 0, 1);
      fetch(32'h200, 0, 0, 0, 1);
      fetch(32'h800, 0, 0, 0, 1);
      fetch(32'h400, 0, 0, 0, 1);
      tick();

      // async reset while requesting
      new_request = 1'b1;
      addr = 32'h600;
      tick();
      new_request = 1'b0;
      tick();
      chk("arst_req_before", l1_request, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_req_l1req", l1_request, 0);
      chk("arst_req_ready", ready, 1);
      #1 rst = 1'b0;
      @(negedge clk);

      // async reset mid-fill with a flush pending
      new_request = 1'b1;
      addr = 32'h614;
      tick();
      new_request = 1'b0;
      tick();
      l1_ack = 1'b1;
      tick();
      l1_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         l1_data_valid = 1'b1;
         l1_data = 32'hBAD0_0000 + 32'(k);
         flush = (k == 1);
         tick();
      end
      l1_data_valid = 1'b0;
      flush = 1'b0;
      chk("arst_fill_busy_before", flush_busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_fill_ready", ready, 1);
      chk("arst_fill_dv", data_valid, 0);
      chk("arst_fill_dout", data_out, 0);
      chk("arst_fill_l1req", l1_request, 0);
      chk("arst_fill_invdone", inv_done, 0);
      chk("arst_fill_busy", flush_busy, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      fetch(32'h614, 0, 0, 0, 1);
      fetch(32'h600, 1, 0, 0, 1);
      fetch(32'h100, 0, 0, 0, 1);
      fetch(32'h104, 1, 0, 0, 1);
      tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
